eject_arbiter: RTL and testbench

- Per-router ejection controller for the 4-port bufferless mesh router.
- Each cycle it selects at most one local-destined flit from the N/S/E/W channels, using round-robin priority, and pushes it into a small ejection FIFO that drains to the PE over a valid/ready handshake.
- Local-destined flits that lose arbitration, or that arrive while the FIFO is full, continue with dir=3'b100 (retry/deflect) so the deflection stage re-routes them.
- Sits between the input pipeline register and the permutation/deflection stage.

---
 rtl/eject_arbiter_if.sv | 44 ++++
 rtl/eject_arbiter.sv | 130 +++++++++++++
 tb/tb_eject_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/eject_arbiter_if.sv
// rtl/eject_arbiter_if.sv - channel, forward and ejection signal bundle for eject_arbiter
// The slave modport is the arbiter's view; master is the driver/PE side.
interface eject_arbiter_if #(
    parameter int CNT_W = 3
);
    logic [10:0]      n_in;
    logic [10:0]      s_in;
    logic [10:0]      e_in;
    logic [10:0]      w_in;
    logic             n_vld;
    logic             s_vld;
    logic             e_vld;
    logic             w_vld;
    logic [10:0]      n_out;
    logic [10:0]      s_out;
    logic [10:0]      e_out;
    logic [10:0]      w_out;
    logic             n_ovld;
    logic             s_ovld;
    logic             e_ovld;
    logic             w_ovld;
    logic [10:0]      lad;
    logic             lad_vld;
    logic             lad_rdy;
    logic [CNT_W-1:0] eject_cnt;

    modport slave (
        input  n_in, s_in, e_in, w_in,
        input  n_vld, s_vld, e_vld, w_vld,
        input  lad_rdy,
        output n_out, s_out, e_out, w_out,
        output n_ovld, s_ovld, e_ovld, w_ovld,
        output lad, lad_vld, eject_cnt
    );

    modport master (
        output n_in, s_in, e_in, w_in,
        output n_vld, s_vld, e_vld, w_vld,
        output lad_rdy,
        input  n_out, s_out, e_out, w_out,
        input  n_ovld, s_ovld, e_ovld, w_ovld,
        input  lad, lad_vld, eject_cnt
    );
endinterface

// File: rtl/eject_arbiter.sv
// rtl/eject_arbiter.sv - round-robin ejection arbiter with show-ahead ejection FIFO
// Local flits that lose arbitration or meet a full FIFO leave with dir=100 for deflection.
module eject_arbiter #(
    parameter logic [2:0] LOCAL_ROW  = 3'b100,
    parameter logic [2:0] LOCAL_COL  = 3'b100,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    eject_arbiter_if.slave   bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] DIR_RETRY = 3'b100;

    logic [10:0]      w_flit [4];
    logic [3:0]       w_vld;
    logic [3:0]       w_req;
    logic             w_space;
    logic             w_grant_vld;
    logic [1:0]       w_grant_idx;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_rr;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [10:0]      r_mem [FIFO_DEPTH];
    logic [10:0]      r_out [4];
    logic [3:0]       r_ovld;

    assign w_flit[0] = bus.n_in;
    assign w_flit[1] = bus.s_in;
    assign w_flit[2] = bus.e_in;
    assign w_flit[3] = bus.w_in;
    assign w_vld     = {bus.w_vld, bus.e_vld, bus.s_vld, bus.n_vld};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_req[i] = w_vld[i] && (w_flit[i][5:3] == LOCAL_ROW) && (w_flit[i][2:0] == LOCAL_COL);
        end
    end

    // Space is judged on the pre-pop count so a same-cycle pop never makes room.
    assign w_space = (r_cnt < DEPTH_C);

    always_comb begin
        logic [1:0] k;
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr;
        k           = r_rr;
        for (int j = 0; j < 4; j++) begin
            k = r_rr + 2'(j);
            if (!w_grant_vld && w_space && w_req[k]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = k;
            end
        end
    end

    assign w_push = w_grant_vld;
    assign w_pop  = (r_cnt != '0) && bus.lad_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 2'd0;
        end else if (w_grant_vld) begin
            r_rr <= w_grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: lad is gated by occupancy, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_flit[w_grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= 11'b0;
            end
            r_ovld <= 4'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!w_vld[i] || (w_grant_vld && (w_grant_idx == 2'(i)))) begin
                    r_out[i]  <= 11'b0;
                    r_ovld[i] <= 1'b0;
                end else if (w_req[i]) begin
                    r_out[i]  <= {w_flit[i][10:9], DIR_RETRY, w_flit[i][5:0]};
                    r_ovld[i] <= 1'b1;
                end else begin
                    r_out[i]  <= w_flit[i];
                    r_ovld[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.n_out     = r_out[0];
    assign bus.s_out     = r_out[1];
    assign bus.e_out     = r_out[2];
    assign bus.w_out     = r_out[3];
    assign bus.n_ovld    = r_ovld[0];
    assign bus.s_ovld    = r_ovld[1];
    assign bus.e_ovld    = r_ovld[2];
    assign bus.w_ovld    = r_ovld[3];
    assign bus.lad_vld   = (r_cnt != '0);
    assign bus.lad       = bus.lad_vld ? r_mem[r_rd_ptr] : 11'b0;
    assign bus.eject_cnt = r_cnt;
endmodule

// File: tb/tb_eject_arbiter.sv
// tb/tb_eject_arbiter.sv - directed self-checking bench for eject_arbiter
module tb_eject_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    eject_arbiter_if #(.CNT_W(3)) bus ();

    eject_arbiter #(
        .LOCAL_ROW (3'b100),
        .LOCAL_COL (3'b100),
        .FIFO_DEPTH(4),
        .CNT_W     (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fwd(input string tag, input logic [3:0] ovld,
                           input logic [10:0] en, input logic [10:0] es,
                           input logic [10:0] ee, input logic [10:0] ew);
        chk({tag, ".ovld"}, {28'd0, bus.w_ovld, bus.e_ovld, bus.s_ovld, bus.n_ovld}, {28'd0, ovld});
        chk({tag, ".n_out"}, {21'd0, bus.n_out}, {21'd0, en});
        chk({tag, ".s_out"}, {21'd0, bus.s_out}, {21'd0, es});
        chk({tag, ".e_out"}, {21'd0, bus.e_out}, {21'd0, ee});
        chk({tag, ".w_out"}, {21'd0, bus.w_out}, {21'd0, ew});
    endtask

    task automatic chk_fifo(input string tag, input logic [10:0] lad, input logic vld, input logic [2:0] cnt);
        chk({tag, ".lad"}, {21'd0, bus.lad}, {21'd0, lad});
        chk({tag, ".lad_vld"}, {31'd0, bus.lad_vld}, {31'd0, vld});
        chk({tag, ".cnt"}, {29'd0, bus.eject_cnt}, {29'd0, cnt});
    endtask

    task automatic drive(input logic [10:0] n, input logic [10:0] s, input logic [10:0] e,
                         input logic [10:0] w, input logic [3:0] vld, input logic rdy);
        bus.n_in = n; bus.s_in = s; bus.e_in = e; bus.w_in = w;
        {bus.w_vld, bus.e_vld, bus.s_vld, bus.n_vld} = vld;
        bus.lad_rdy = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(11'h024, 11'h024, 11'h024, 11'h024, 4'hF, 1'b1);

        // Reset held with flits driven
        tick();
        chk_fwd("rst1", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        chk_fifo("rst1", 11'h0, 1'b0, 3'd0);
        tick();
        chk_fwd("rst2", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        chk_fifo("rst2", 11'h0, 1'b0, 3'd0);

        // Single eject from N
        rst_n = 1'b1;
        drive(11'h024, 11'h0, 11'h0, 11'h0, 4'b0001, 1'b0);
        tick();
        chk_fwd("single", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        chk_fifo("single", 11'h024, 1'b1, 3'd1);

        // Pointer now at S: S and E both local, S wins
        drive(11'h0, 11'h224, 11'h424, 11'h0, 4'b0110, 1'b1);
        tick();
        chk_fwd("rr_s", 4'b0100, 11'h0, 11'h0, 11'h524, 11'h0);
        chk_fifo("rr_s", 11'h224, 1'b1, 3'd1);

        // Fresh reset so contention starts from N
        rst_n = 1'b0;
        drive(11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0);
        #2;
        rst_n = 1'b1;
        drive(11'h024, 11'h024, 11'h024, 11'h024, 4'hF, 1'b1);
        tick();
        chk_fwd("cont1", 4'b1110, 11'h0, 11'h124, 11'h124, 11'h124);
        chk_fifo("cont1", 11'h024, 1'b1, 3'd1);
        tick();
        chk_fwd("cont2", 4'b1101, 11'h124, 11'h0, 11'h124, 11'h124);
        chk("cont2.cnt", {29'd0, bus.eject_cnt}, 32'd1);
        tick();
        chk_fwd("cont3", 4'b1011, 11'h124, 11'h124, 11'h0, 11'h124);
        chk("cont3.cnt", {29'd0, bus.eject_cnt}, 32'd1);
        tick();
        chk_fwd("cont4", 4'b0111, 11'h124, 11'h124, 11'h124, 11'h0);
        chk("cont4.cnt", {29'd0, bus.eject_cnt}, 32'd1);

        // Drain to empty, then pop request on empty must not underflow
        drive(11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b1);
        tick();
        chk_fwd("drain", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        chk_fifo("drain", 11'h0, 1'b0, 3'd0);
        tick();
        chk_fifo("empty_rdy", 11'h0, 1'b0, 3'd0);

        // Fill from E with distinct gs tags; 5th is deflected
        drive(11'h0, 11'h0, 11'h024, 11'h0, 4'b0100, 1'b0);
        tick();
        chk("fill1.cnt", {29'd0, bus.eject_cnt}, 32'd1);
        bus.e_in = 11'h224;
        tick();
        chk("fill2.cnt", {29'd0, bus.eject_cnt}, 32'd2);
        bus.e_in = 11'h424;
        tick();
        chk("fill3.cnt", {29'd0, bus.eject_cnt}, 32'd3);
        bus.e_in = 11'h624;
        tick();
        chk_fwd("fill4", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        chk_fifo("fill4", 11'h024, 1'b1, 3'd4);
        bus.e_in = 11'h024;
        tick();
        chk_fwd("full5", 4'b0100, 11'h0, 11'h0, 11'h124, 11'h0);
        chk_fifo("full5", 11'h024, 1'b1, 3'd4);

        // Pop while full with a local flit: no grant, count drops
        bus.e_in = 11'h224;
        bus.lad_rdy = 1'b1;
        tick();
        chk_fwd("full_pop", 4'b0100, 11'h0, 11'h0, 11'h324, 11'h0);
        chk_fifo("full_pop", 11'h224, 1'b1, 3'd3);

        // Pass-through of a non-local flit
        drive(11'h0, 11'h0, 11'h0, 11'h2B4, 4'b1000, 1'b0);
        tick();
        chk_fwd("pass", 4'b1000, 11'h0, 11'h0, 11'h0, 11'h2B4);
        chk_fifo("pass", 11'h224, 1'b1, 3'd3);

        // Pointer still at W after full cycles and pass-through
        drive(11'h624, 11'h0, 11'h0, 11'h024, 4'b1001, 1'b0);
        tick();
        chk_fwd("rr_w", 4'b0001, 11'h724, 11'h0, 11'h0, 11'h0);
        chk_fifo("rr_w", 11'h224, 1'b1, 3'd4);

        drive(11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b1);
        tick();
        chk_fifo("pop3", 11'h424, 1'b1, 3'd3);

        // Async reset mid-cycle with three entries held
        bus.lad_rdy = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_fifo("async", 11'h0, 1'b0, 3'd0);
        chk_fwd("async", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        #2;
        rst_n = 1'b1;
        drive(11'h0, 11'h624, 11'h0, 11'h0, 4'b0010, 1'b0);
        tick();
        chk_fwd("post_rst", 4'h0, 11'h0, 11'h0, 11'h0, 11'h0);
        chk_fifo("post_rst", 11'h624, 1'b1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
